// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults and types for the two-master memory arbiter.
//   AW_DEF / DW_DEF      default address / data widths
//   MAX_BURST_DEF        default cap on consecutive grants while the other master waits
//   state_t              arbiter FSM state (IDLE, OWN0, OWN1)
//   burst_cnt_w()        width of the burst counter for a given cap
package mem_arb_pkg;

  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 16;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // One extra bit so the counter can hold MAX_BURST itself.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/mem_arb_burst_cnt.sv
// mem_arb_burst_cnt: consecutive-grant counter for the memory arbiter.
//   clk, rst_n   clock, asynchronous active-low reset (count clears to 0)
//   i_load       grant to a new owner: count becomes 1
//   i_inc        another grant to the same owner: count + 1, saturating at MAX_BURST
//   o_cnt        current count
module mem_arb_burst_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CW        = burst_cnt_w(MAX_BURST)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_inc && (r_cnt < CW'(MAX_BURST))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, single-port memory arbiter. A grant completes the
// access in the same cycle; read data returns registered one cycle later.
//   clk, rst_n                 clock, asynchronous active-low reset
//   m0_* / m1_*                master request, write flag, address, write data (in);
//                              grant (comb), read valid and registered read data (out)
//   mem_addr, mem_idata, mem_wr   memory address / write data / write strobe
//   mem_odata                  combinational memory read of mem_addr
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_idata,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_odata
);

  localparam int CW = burst_cnt_w(MAX_BURST);

  state_t        r_state;
  state_t        w_next;
  logic          r_last_owner;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_load;
  logic          w_inc;
  logic          w_below;
  logic [CW-1:0] w_cnt;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  mem_arb_burst_cnt #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_burst_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_inc  (w_inc),
    .o_cnt  (w_cnt)
  );

  // Owner may keep the bus while the other waits only below the burst cap.
  assign w_below = (w_cnt < CW'(MAX_BURST));

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          if (r_last_owner) w_gnt0 = 1'b1;
          else              w_gnt1 = 1'b1;
        end else if (m0_req) begin
          w_gnt0 = 1'b1;
        end else if (m1_req) begin
          w_gnt1 = 1'b1;
        end
      end
      OWN0: begin
        if (m0_req && (!m1_req || w_below)) w_gnt0 = 1'b1;
        else if (m1_req)                    w_gnt1 = 1'b1;
      end
      OWN1: begin
        if (m1_req && (!m0_req || w_below)) w_gnt1 = 1'b1;
        else if (m0_req)                    w_gnt0 = 1'b1;
      end
      default: ;
    endcase
    // Grants are combinational, so they must also be held off during reset.
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
    if (w_gnt0)      w_next = OWN0;
    else if (w_gnt1) w_next = OWN1;
    else             w_next = IDLE;
  end

  // A grant that changes (or establishes) ownership restarts the burst count.
  assign w_load = (w_gnt0 && (r_state != OWN0)) || (w_gnt1 && (r_state != OWN1));
  assign w_inc  = (w_gnt0 || w_gnt1) && !w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state   <= w_next;
      r_rvalid0 <= w_gnt0 && !m0_wr;
      r_rvalid1 <= w_gnt1 && !m1_wr;
      if (w_gnt0)      r_last_owner <= 1'b0;
      else if (w_gnt1) r_last_owner <= 1'b1;
      if (w_gnt0 && !m0_wr) r_rdata0 <= mem_odata;
      if (w_gnt1 && !m1_wr) r_rdata1 <= mem_odata;
    end
  end

  // Idle bus defaults to master 0's address and data with no strobe.
  assign mem_addr  = w_gnt1 ? m1_addr  : m0_addr;
  assign mem_idata = w_gnt1 ? m1_wdata : m0_wdata;
  assign mem_wr    = (w_gnt0 && m0_wr) || (w_gnt1 && m1_wr);

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. The driver applies one
// access pattern per cycle, runs a reference arbiter model and pushes the
// expected bus/grant values and expected read returns into queues; the
// monitor pops and compares them against the DUT each cycle.
module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXB = 8;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m1_req, m0_wr, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_idata;
  logic          mem_wr;
  logic [DW-1:0] mem_odata;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_wr     (m0_wr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_wr     (m1_wr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_idata (mem_idata),
    .mem_wr    (mem_wr),
    .mem_odata (mem_odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT.
  logic [DW-1:0] phys [0:65535];
  always @(posedge clk) if (mem_wr) phys[mem_addr] <= mem_idata;
  assign mem_odata = phys[mem_addr];

  typedef struct {
    bit            g0;
    bit            g1;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] idata;
  } bus_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  bus_t gq[$];
  rd_t  rdq0[$];
  rd_t  rdq1[$];

  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] hold0, hold1;
  int cyc;
  int cmp_n, fail_n;

  // Reference arbiter: owner -1 means nobody owns the bus.
  int owner, run, last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit r0, input bit w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input bit r1, input bit w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int   g;
    bit   mine, other;
    bus_t e;
    rd_t  rd;
    @(negedge clk);
    cyc++;
    rst_n = ~rst; m0_req = r0; m0_wr = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wr = w1; m1_addr = a1; m1_wdata = d1;
    g = -1;
    if (rst) begin
      owner = -1; run = 0; last = 1;
      rdq0.delete(); rdq1.delete();
      hold0 = '0; hold1 = '0;
    end else begin
      if (owner < 0) begin
        if (r0 && r1)  g = 1 - last;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
      end else begin
        mine  = (owner == 0) ? r0 : r1;
        other = (owner == 0) ? r1 : r0;
        if (mine && (!other || run < MAXB)) g = owner;
        else if (other)                     g = 1 - owner;
      end
      if (g >= 0) begin
        run   = (g == owner) ? ((run < MAXB) ? run + 1 : MAXB) : 1;
        owner = g;
        last  = g;
      end else begin
        owner = -1;
      end
    end
    e.g0    = (g == 0);
    e.g1    = (g == 1);
    e.addr  = (g == 1) ? a1 : a0;
    e.idata = (g == 1) ? d1 : d0;
    e.wr    = (g == 0) ? w0 : ((g == 1) ? w1 : 1'b0);
    gq.push_back(e);
    if (g >= 0) begin
      if (e.wr) begin
        ref_mem[e.addr] = e.idata;
      end else begin
        rd.due  = cyc + 1;
        rd.data = ref_mem[e.addr];
        if (g == 0) rdq0.push_back(rd);
        else        rdq1.push_back(rd);
      end
    end
  endtask

  task automatic rand_step(input bit both_bias);
    bit r0, r1;
    r0 = both_bias ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
    r1 = both_bias ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
    step(0, r0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
            r1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
  endtask

  // Monitor: compares DUT outputs against the queued expectations each cycle.
  initial begin
    bus_t e;
    bit   ev0, ev1;
    forever begin
      @(negedge clk);
      #3;
      if (gq.size() > 0) begin
        e = gq.pop_front();
        chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
        chk("mem_wr", 32'(mem_wr), 32'(e.wr));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_idata", 32'(mem_idata), 32'(e.idata));
        ev0 = (rdq0.size() > 0) && (rdq0[0].due == cyc);
        ev1 = (rdq1.size() > 0) && (rdq1[0].due == cyc);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
        if (ev0) hold0 = rdq0.pop_front().data;
        if (ev1) hold1 = rdq1.pop_front().data;
        chk("m0_rdata", 32'(m0_rdata), 32'(hold0));
        chk("m1_rdata", 32'(m1_rdata), 32'(hold1));
      end
    end
  end

  initial begin
    cmp_n = 0; fail_n = 0; cyc = 0;
    owner = -1; run = 0; last = 1;
    hold0 = '0; hold1 = '0;
    for (int i = 0; i < 65536; i++) begin
      phys[i]    = '0;
      ref_mem[i] = '0;
    end
    rst_n = 1'b0;
    m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;

    // Reset with requests pending: no grants, no strobes.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 16'h0003, 16'hBEEF, 1, 0, 16'h0004, 16'h0);

    // Both masters request continuously from reset: 8/8 alternation.
    for (int i = 0; i < 40; i++)
      step(0, 1, 0, AW'(i % 16), 16'h0, 1, 0, AW'((i + 5) % 16), 16'h0);

    // Nobody requests: bus idle, memory untouched.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h0010, 16'hDEAD, 0, 1, 16'h0011, 16'hDEAD);

    // m0 writes 0x1234 to 0x0010, m1 reads it the next cycle.
    step(0, 1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

    // m1 alone for 20 cycles, then m0 joins against a saturated burst.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0010, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

    // m0 served last, bus idles, then both request: m1 first.
    step(0, 1, 1, 16'h0005, 16'h5555, 0, 0, 16'h0, 16'h0);
    step(0, 1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    step(0, 1, 0, 16'h0005, 16'h0, 1, 0, 16'h0005, 16'h0);
    step(0, 1, 0, 16'h0005, 16'h0, 1, 0, 16'h0005, 16'h0);

    // Reset mid-burst while a read has just been granted.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0005, 16'h0);
    for (int i = 0; i < 2; i++) step(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0005, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0005, 16'h0);

    // Randomized traffic, then mostly-contended traffic.
    for (int i = 0; i < 300; i++) rand_step(0);
    for (int i = 0; i < 200; i++) rand_step(1);

    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    #5;
    chk("drain_bus_q", 32'(gq.size()), 32'd0);
    chk("drain_rd_q", 32'(rdq0.size() + rdq1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 16, address width
- DW, 16, data width
- MAX_BURST, 8, max consecutive grants to one master while the other waits
REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  master access request
- m0_wr / m1_wr  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  access address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid
- m0_rdata / m1_rdata  out  DW  registered read data
- mem_addr  out  AW  to memory address
- mem_idata  out  DW  to memory write data
- mem_wr  out  1  to memory write strobe
- mem_odata  in  DW  from memory, combinational read of mem_addr
REQ-003 One clock and one reset; reset is asynchronous, active-low, on rst_n.

Function
REQ-004 At most one of m0_gnt, m1_gnt SHALL be high per cycle; a gnt is only high when the same master's req is high.
REQ-005 Grant SHALL mean the access completes this cycle: mem_addr/mem_idata come from the granted master; mem_wr = gnt AND that master's wr.
REQ-006 With no grant: mem_wr = 0, mem_addr = m0_addr, mem_idata = m0_wdata.
REQ-007 FSM states SHALL be IDLE, OWN0, OWN1, held in a register; grants are decoded combinationally from state, req and burst count.
REQ-008 IDLE: single requester granted; both requesting -> grant master != last_owner (last_owner resets to 1, so m0 wins first); next state OWNx of the grantee.
REQ-009 OWNx: grant x if x requests AND (other not requesting OR burst_cnt < MAX_BURST); else grant the other if it requests, next state OWNother; neither requests -> no grant, next state IDLE.
REQ-010 burst_cnt SHALL load 1 on a grant to a new owner or from IDLE and increment on each consecutive grant to the same owner, saturating at MAX_BURST.
REQ-011 last_owner SHALL update to the granted master on every grant.
REQ-012 Read granted in cycle N: mx_rdata <= mem_odata and mx_rvalid = 1 in cycle N+1, for exactly one cycle per read; rdata holds until the next read to that master.
REQ-013 Writes SHALL produce no rvalid; a write at address A granted in cycle N is visible to any read granted in cycle N+1 or later.
REQ-014 Back-to-back grants to alternating masters every cycle SHALL be supported with no bubble cycles.
REQ-015 Request dropped while owning: no grant that cycle unless the other requests (REQ-009); no timeout, no starvation beyond MAX_BURST cycles.

Reset
REQ-016 Asserting rst_n low SHALL immediately force state IDLE, burst_cnt 0, last_owner 1, m0/m1_rvalid 0, m0/m1_rdata 0; a read granted in the cycle of reset returns no rvalid.
REQ-017 gnt and mem_wr are combinational and SHALL be 0 while rst_n is low.

Structure
REQ-018 Package mem_arb_pkg SHALL hold AW, DW, MAX_BURST defaults and the state enum (IDLE, OWN0, OWN1).
REQ-019 One sub-module, mem_arb_burst_cnt (load/increment/saturate counter, width clog2(MAX_BURST)+1), SHALL be used; all else stays in mem_arbiter.

Verification
REQ-020 Bench SHALL cover:
- m0 writes 0x1234 to 0x0010, next cycle m1 reads 0x0010 -> m1_gnt at once, m1_rvalid=1 with 0x1234 one cycle later.
- Both req from reset, continuous -> m0 granted 8 cycles, then m1 8 cycles, alternating; no cycle without a grant.
- Only m1 requests for 20 cycles -> m1_gnt every cycle, burst_cnt saturates at 8, no forced switch.
- Both req in IDLE after m0 last served -> m1 granted first.
- rst_n low mid-burst during a granted read -> rvalid stays 0, state IDLE, both gnt 0 until rst_n high; next dual request grants m0.
- Neither req -> mem_wr 0 every cycle, memory unchanged.
